// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready handshake between the host byte source
// and the instruction loader.
interface instr_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/instr_loader.sv
// Loads a byte stream (count, then opcode/literal pairs) into instruction memory.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
   parameter int ADDR_W  = 4,
   parameter int INSTR_W = 15,
   parameter int DEPTH   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   instr_loader_if.slave      bus,
   output logic               we,
   output logic [ADDR_W-1:0]  waddr,
   output logic [INSTR_W-1:0] wdata,
   output logic               cpu_hold,
   output logic               done,
   output logic               error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT,
      S_OP,
      S_LIT,
      S_WR,
      S_DONE,
      S_ERR
`ifdef INSTR_LOADER_CHECKSUM_EN
      , S_CHK
`endif
   } state_t;

   localparam logic [8:0] DEPTH_B = 9'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] last;
   logic [6:0]        opcode;
   logic              accept;
   logic              bad_cnt;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign accept  = bus.in_valid && bus.in_ready;
   assign bad_cnt = (bus.in_data == 8'd0) ||
                    ({1'b0, bus.in_data} > DEPTH_B);

   // Ready is a pure state decode so it never depends on in_valid.
   always_comb begin
      bus.in_ready = 1'b0;
      unique case (state)
         S_CNT, S_OP, S_LIT: bus.in_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CHK: bus.in_ready = 1'b1;
`endif
         default: bus.in_ready = 1'b0;
      endcase
   end

   // Loader FSM with registered outputs; reset wins over start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
         last     <= '0;
         opcode   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_CNT;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
               end
            end
            S_CNT: begin
               if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum <= bus.in_data;
`endif
                  if (bad_cnt) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else begin
                     last  <= ADDR_W'(bus.in_data - 8'd1);
                     waddr <= '0;
                     state <= S_OP;
                  end
               end
            end
            S_OP: begin
               if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum <= csum ^ bus.in_data;
`endif
                  if (bus.in_data[7]) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else begin
                     opcode <= bus.in_data[6:0];
                     state  <= S_LIT;
                  end
               end
            end
            S_LIT: begin
               if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  csum <= csum ^ bus.in_data;
`endif
                  wdata <= INSTR_W'({opcode, bus.in_data});
                  we    <= 1'b1;
                  state <= S_WR;
               end
            end
            S_WR: begin
               if (waddr == last) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  state    <= S_CHK;
`else
                  state    <= S_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
`endif
               end else begin
                  waddr <= waddr + ADDR_W'(1);
                  state <= S_OP;
               end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (accept) begin
                  if (bus.in_data == csum) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
